// File: rtl/truth_table_sweeper.sv
// Purpose: drive every input vector into a combinational DUT, capture its truth table, compare to expected.
// Latency: done pulses the cycle after edge E0 + 2**N_IN*SETTLE; back-to-back period 2**N_IN*SETTLE+1.
// Backpressure: none; start is only taken in IDLE, start while busy is dropped (no queuing).
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 f,
  output logic [N_IN-1:0]      dut_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN-1:0]      fail_idx,
  output logic                 fail_valid
);

  localparam int W  = 2**N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IN_LAST  = '1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    exp_q;
  logic            accept;
  logic            sample;
  logic            last;
  logic [W-1:0]    tbl_final;
  logic [W-1:0]    diff;
  logic [N_IN-1:0] idx_lo;

  assign accept = (state == IDLE) && start;
  assign sample = (state == SWEEP) && (cnt == CNT_LAST);
  assign last   = sample && (dut_in == IN_LAST);

  // Table as it will look once the current sample lands; the final verdict needs the last bit too.
  always_comb begin
    tbl_final         = table_out;
    tbl_final[dut_in] = f;
    diff              = tbl_final ^ exp_q;
  end

  // Lowest mismatching index wins; scan high to low so the lowest assignment sticks.
  always_comb begin
    idx_lo = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (diff[i]) idx_lo = N_IN'(i);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: enter SWEEP on an accepted start, leave after the last vector is sampled.
  always_comb begin
    state_nxt = state;
    if (accept)    state_nxt = SWEEP;
    else if (last) state_nxt = IDLE;
  end

  // Busy is exactly the SWEEP state.
  always_comb begin
    busy = (state == SWEEP);
  end

  // Datapath: vector stepping, settle counting, table capture and final verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in     <= '0;
      cnt        <= '0;
      exp_q      <= '0;
      table_out  <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_idx   <= '0;
      fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        exp_q      <= expected;
        dut_in     <= '0;
        cnt        <= '0;
        table_out  <= '0;
        pass       <= 1'b0;
        fail_idx   <= '0;
        fail_valid <= 1'b0;
      end else if (state == SWEEP) begin
        if (!sample) begin
          cnt <= cnt + 1'b1;
        end else begin
          cnt       <= '0;
          table_out <= tbl_final;
          if (dut_in != IN_LAST) begin
            dut_in <= dut_in + 1'b1;
          end else begin
            // dut_in parks at its last value in IDLE; results hold until the next start.
            done       <= 1'b1;
            pass       <= (diff == '0);
            fail_idx   <= idx_lo;
            fail_valid <= (diff != '0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Purpose: self-checking bench for truth_table_sweeper with a parity DUT and a 1-input inverter DUT.
// Latency: checks done timing per sweep; results are scoreboarded on each done pulse.
// Backpressure: exercises ignored start while busy and back-to-back starts.
module tb_truth_table_sweeper;

  typedef struct {
    logic [7:0] tbl;
    logic       pass;
    logic [2:0] idx;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] expected;
  logic       f;
  logic [2:0] dut_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] table_out;
  logic [2:0] fail_idx;
  logic       fail_valid;

  logic       start_s;
  logic [1:0] expected_s;
  logic       f_s;
  logic [0:0] dut_in_s;
  logic       busy_s;
  logic       done_s;
  logic       pass_s;
  logic [1:0] table_out_s;
  logic [0:0] fail_idx_s;
  logic       fail_valid_s;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  assign f   = dut_in[2] ^ dut_in[1] ^ dut_in[0];
  assign f_s = ~dut_in_s[0];

  truth_table_sweeper #(.N_IN(3), .SETTLE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .f(f),
    .dut_in(dut_in), .busy(busy), .done(done), .pass(pass), .table_out(table_out),
    .fail_idx(fail_idx), .fail_valid(fail_valid)
  );

  truth_table_sweeper #(.N_IN(1), .SETTLE(1)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .expected(expected_s), .f(f_s),
    .dut_in(dut_in_s), .busy(busy_s), .done(done_s), .pass(pass_s), .table_out(table_out_s),
    .fail_idx(fail_idx_s), .fail_valid(fail_valid_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: 3-input parity table, then compare against expected like the spec describes.
  function automatic exp_t model(input logic [7:0] e);
    exp_t       m;
    logic [2:0] v;
    bit         found;
    found = 1'b0;
    m.idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      v        = 3'(i);
      m.tbl[i] = v[2] ^ v[1] ^ v[0];
    end
    m.pass = (m.tbl == e);
    for (int i = 0; i < 8; i++) begin
      if (!found && (m.tbl[i] != e[i])) begin
        m.idx = 3'(i);
        found = 1'b1;
      end
    end
    return m;
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    exp_t m;
    if (done === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: done seen with empty scoreboard");
      end else begin
        m = sb.pop_front();
        total += 4;
        if (table_out !== m.tbl) begin
          bad++; $display("FAIL sb_table: got %h want %h", table_out, m.tbl);
        end
        if (pass !== m.pass) begin
          bad++; $display("FAIL sb_pass: got %b want %b", pass, m.pass);
        end
        if (fail_idx !== m.idx) begin
          bad++; $display("FAIL sb_fail_idx: got %0d want %0d", fail_idx, m.idx);
        end
        if (fail_valid !== !m.pass) begin
          bad++; $display("FAIL sb_fail_valid: got %b want %b", fail_valid, !m.pass);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; expected = 8'hff;
    start_s = 1'b0; expected_s = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({dut_in, busy, done, pass, table_out, fail_idx, fail_valid} !== 17'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0",
                      {dut_in, busy, done, pass, table_out, fail_idx, fail_valid});
    end
    rst_n = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || dut_in !== 3'd0) begin
      bad++; $display("FAIL reset_idle: busy=%b done=%b dut_in=%0d want 0 0 0", busy, done, dut_in);
    end
  endtask

  task automatic test_parity(input logic [7:0] e);
    int c;
    expected = e; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back(model(e));
    c = 0;
    while (done !== 1'b1 && c < 40) begin
      total++;
      if (busy !== 1'b1 || dut_in !== 3'(c / 2)) begin
        bad++; $display("FAIL parity_step exp=%h c=%0d: busy=%b dut_in=%0d want 1 %0d", e, c, busy, dut_in, c / 2);
      end
      @(posedge clk); #1;
      c++;
    end
    total++;
    if (c != 16 || busy !== 1'b0) begin
      bad++; $display("FAIL parity_latency exp=%h: cycles=%0d busy=%b want 16 0", e, c, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_and_back_to_back();
    int c;
    expected = 8'h96; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back(model(8'h96));
    c = 0;
    while (done !== 1'b1 && c < 40) begin
      if (c == 5) begin start = 1'b1; expected = 8'h00; end
      if (c == 6) start = 1'b0;
      if (c == 15) begin start = 1'b1; expected = 8'h97; end
      @(posedge clk); #1;
      c++;
    end
    total++;
    if (c != 16) begin
      bad++; $display("FAIL ignore_latency: cycles=%0d want 16", c);
    end
    @(posedge clk); #1;
    sb.push_back(model(8'h97));
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || table_out !== 8'h00 || pass !== 1'b0 || dut_in !== 3'd0) begin
      bad++; $display("FAIL b2b_accept: done=%b busy=%b tbl=%h pass=%b dut_in=%0d want 0 1 00 0 0",
                      done, busy, table_out, pass, dut_in);
    end
    c = 1;
    while (done !== 1'b1 && c < 60) begin
      @(posedge clk); #1;
      c++;
    end
    total++;
    if (c != 17) begin
      bad++; $display("FAIL b2b_period: done gap=%0d want 17", c);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int c;
    expected = 8'h96; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || dut_in !== 3'd0 || table_out !== 8'h00 || done !== 1'b0) begin
      bad++; $display("FAIL arst_immediate: busy=%b dut_in=%0d tbl=%h done=%b want 0 0 00 0",
                      busy, dut_in, table_out, done);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL arst_idle: busy=%b done=%b want 0 0", busy, done);
    end
    expected = 8'h96; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back(model(8'h96));
    c = 0;
    while (done !== 1'b1 && c < 40) begin
      total++;
      if (dut_in !== 3'(c / 2)) begin
        bad++; $display("FAIL arst_step c=%0d: dut_in=%0d want %0d", c, dut_in, c / 2);
      end
      @(posedge clk); #1;
      c++;
    end
    total++;
    if (c != 16) begin
      bad++; $display("FAIL arst_latency: cycles=%0d want 16", c);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_n1_settle1();
    expected_s = 2'b01; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    total++;
    if (dut_in_s !== 1'b0 || busy_s !== 1'b1) begin
      bad++; $display("FAIL n1_vec0: dut_in=%b busy=%b want 0 1", dut_in_s, busy_s);
    end
    @(posedge clk); #1;
    total++;
    if (dut_in_s !== 1'b1 || busy_s !== 1'b1 || done_s !== 1'b0) begin
      bad++; $display("FAIL n1_vec1: dut_in=%b busy=%b done=%b want 1 1 0", dut_in_s, busy_s, done_s);
    end
    @(posedge clk); #1;
    total++;
    if (done_s !== 1'b1 || busy_s !== 1'b0 || pass_s !== 1'b1 || table_out_s !== 2'b01 ||
        fail_valid_s !== 1'b0 || fail_idx_s !== 1'b0) begin
      bad++; $display("FAIL n1_result: done=%b busy=%b pass=%b tbl=%b fv=%b idx=%b want 1 0 1 01 0 0",
                      done_s, busy_s, pass_s, table_out_s, fail_valid_s, fail_idx_s);
    end
    @(posedge clk); #1;
    total++;
    if (done_s !== 1'b0 || dut_in_s !== 1'b1 || table_out_s !== 2'b01) begin
      bad++; $display("FAIL n1_hold: done=%b dut_in=%b tbl=%b want 0 1 01", done_s, dut_in_s, table_out_s);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; expected = 8'h00;
    start_s = 1'b0; expected_s = 2'b00;
    test_reset();
    test_parity(8'h96);
    test_parity(8'h97);
    test_parity(8'h16);
    test_parity(8'h90);
    test_ignore_and_back_to_back();
    test_async_reset();
    test_n1_settle1();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_leftover: %0d results never produced, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
